// File: rtl/mips_cpu_pkg.sv
// Shared encodings for the multi-cycle MIPS core: controller states,
// instruction classes, ALUOp codes and the opcode/funct values decoded.
package mips_cpu_pkg;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXEC      = 3'd2,
    ST_MEM       = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALTED    = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    CLS_ALU    = 2'd0,  // result goes through WRITEBACK
    CLS_LOAD   = 2'd1,
    CLS_STORE  = 2'd2,
    CLS_PCONLY = 2'd3   // branches and j/jr/jalr: only the PC is written
  } instr_class_e;

  localparam logic [3:0] ALUOP_ADD    = 4'b0000;
  localparam logic [3:0] ALUOP_BEQ    = 4'b0001;
  localparam logic [3:0] ALUOP_RTYPE  = 4'b0010;
  localparam logic [3:0] ALUOP_AND    = 4'b0100;
  localparam logic [3:0] ALUOP_OR     = 4'b0101;
  localparam logic [3:0] ALUOP_XOR    = 4'b0110;
  localparam logic [3:0] ALUOP_SLT    = 4'b0111;
  localparam logic [3:0] ALUOP_BNE    = 4'b1000;
  localparam logic [3:0] ALUOP_BGTZ   = 4'b1001;
  localparam logic [3:0] ALUOP_BLEZ   = 4'b1010;
  localparam logic [3:0] ALUOP_REGIMM = 4'b1011;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0a;
  localparam logic [5:0] OP_SLTIU  = 6'h0b;
  localparam logic [5:0] OP_ANDI   = 6'h0c;
  localparam logic [5:0] OP_ORI    = 6'h0d;
  localparam logic [5:0] OP_XORI   = 6'h0e;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2b;

  localparam logic [5:0] FN_JR     = 6'h08;
  localparam logic [5:0] FN_JALR   = 6'h09;

endpackage

// File: rtl/mips_cpu_instr_class.sv
// Combinational instruction-class decode: which path the controller takes
// after EXEC and which ALUOp the ALU control decoder sees during EXEC.
module mips_cpu_instr_class
  import mips_cpu_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  output instr_class_e instr_class,
  output logic [3:0]   alu_op,
  output logic         is_jr
);

  // Map opcode (and funct for R-type) to class and EXEC ALUOp.
  always_comb begin
    instr_class = CLS_ALU;
    alu_op      = ALUOP_ADD;
    is_jr       = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        alu_op = ALUOP_RTYPE;
        if (funct == FN_JR) begin
          instr_class = CLS_PCONLY;
          is_jr       = 1'b1;
        end else if (funct == FN_JALR) begin
          instr_class = CLS_PCONLY;
        end else begin
          instr_class = CLS_ALU;
        end
      end
      OP_REGIMM: begin alu_op = ALUOP_REGIMM; instr_class = CLS_PCONLY; end
      OP_J:      instr_class = CLS_PCONLY;
      OP_BEQ:    begin alu_op = ALUOP_BEQ;  instr_class = CLS_PCONLY; end
      OP_BNE:    begin alu_op = ALUOP_BNE;  instr_class = CLS_PCONLY; end
      OP_BLEZ:   begin alu_op = ALUOP_BLEZ; instr_class = CLS_PCONLY; end
      OP_BGTZ:   begin alu_op = ALUOP_BGTZ; instr_class = CLS_PCONLY; end
      OP_ADDIU:  alu_op = ALUOP_ADD;
      OP_SLTI, OP_SLTIU: alu_op = ALUOP_SLT;
      OP_ANDI:   alu_op = ALUOP_AND;
      OP_ORI:    alu_op = ALUOP_OR;
      OP_XORI:   alu_op = ALUOP_XOR;
      OP_LW:     instr_class = CLS_LOAD;
      OP_SW:     instr_class = CLS_STORE;
      default: begin
        instr_class = CLS_ALU;
        alu_op      = ALUOP_ADD;
      end
    endcase
  end

endmodule

// File: rtl/mips_cpu_state_control.sv
// Multi-cycle MIPS controller: FETCH/DECODE/EXEC/MEM/WRITEBACK sequencing,
// memory handshake on waitrequest and halt when the next PC is zero.
module mips_cpu_state_control
  import mips_cpu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic [4:0] rt_field,
  input  logic       waitrequest,
  input  logic       pc_is_zero,
  output logic       mem_read,
  output logic       mem_write,
  output logic       addr_sel,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [3:0] alu_op,
  output logic       active,
  output logic [2:0] state
);

  state_e       state_q, state_d;
  state_e       after_pc_s;
  logic         fresh_q, fresh_d;   // first cycle after reset: strobes held off
  instr_class_e cls_s;
  logic [3:0]   exec_alu_op_s;
  logic         is_jr_s;
  logic         unused_rt_s;

  // Every REGIMM branch shares one class and ALUOp, so rt only rides along.
  assign unused_rt_s = ^rt_field;
  assign state       = state_q;

  mips_cpu_instr_class u_instr_class (
    .opcode      (opcode),
    .funct       (funct),
    .instr_class (cls_s),
    .alu_op      (exec_alu_op_s),
    .is_jr       (is_jr_s)
  );

  // Where the controller goes after any cycle that commits the PC.
  always_comb begin
    if (pc_is_zero) begin
      after_pc_s = ST_HALTED;
    end else begin
      after_pc_s = ST_FETCH;
    end
  end

  // State register; reset parks in FETCH with one strobe-free cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
      fresh_q <= 1'b1;
    end else begin
      state_q <= state_d;
      fresh_q <= fresh_d;
    end
  end

  // Next state and Moore strobes; waitrequest only qualifies the releases.
  always_comb begin
    state_d   = state_q;
    fresh_d   = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    addr_sel  = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    reg_write = 1'b0;
    alu_op    = ALUOP_ADD;
    active    = 1'b1;
    case (state_q)
      ST_FETCH: begin
        if (fresh_q) begin
          state_d = ST_FETCH;
        end else begin
          mem_read = 1'b1;
          if (!waitrequest) begin
            ir_write = 1'b1;
            state_d  = ST_DECODE;
          end else begin
            state_d = ST_FETCH;
          end
        end
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        alu_op = exec_alu_op_s;
        case (cls_s)
          CLS_LOAD, CLS_STORE: state_d = ST_MEM;
          CLS_PCONLY: begin
            pc_write = 1'b1;
            state_d  = after_pc_s;
          end
          default: state_d = ST_WRITEBACK;
        endcase
      end
      ST_MEM: begin
        addr_sel = 1'b1;
        if (cls_s == CLS_LOAD) begin
          mem_read = 1'b1;
          if (!waitrequest) begin
            state_d = ST_WRITEBACK;
          end else begin
            state_d = ST_MEM;
          end
        end else begin
          mem_write = (cls_s == CLS_STORE);
          if (!waitrequest) begin
            pc_write = 1'b1;
            state_d  = after_pc_s;
          end else begin
            state_d = ST_MEM;
          end
        end
      end
      ST_WRITEBACK: begin
        reg_write = !is_jr_s;
        pc_write  = 1'b1;
        state_d   = after_pc_s;
      end
      ST_HALTED: begin
        active  = 1'b0;
        state_d = ST_HALTED;
      end
      default: state_d = ST_FETCH;
    endcase
  end

endmodule

// File: tb/tb_mips_cpu_state_control.sv
// Self-checking bench: a per-instruction cycle-trace model built from the
// controller's documented behaviour, compared cycle by cycle with the DUT.
module tb_mips_cpu_state_control;

  logic       clk = 1'b0;
  logic       reset, waitrequest, pc_is_zero;
  logic [5:0] opcode, funct;
  logic [4:0] rt_field;
  logic       mem_read, mem_write, addr_sel, ir_write, pc_write, reg_write, active;
  logic [3:0] alu_op;
  logic [2:0] state;

  localparam logic [6:0] MR  = 7'b1000000, MW  = 7'b0100000, AS = 7'b0010000;
  localparam logic [6:0] IRW = 7'b0001000, PCW = 7'b0000100, RW = 7'b0000010;
  localparam logic [6:0] ACT = 7'b0000001;
  localparam int K_WB = 0, K_LD = 1, K_ST = 2, K_PC = 3;

  typedef struct packed {
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rt;
    logic       rs, wr, pz;
    logic [2:0] st;
    logic       mr, mw, as, irw, pcw, rw, act;
    logic [3:0] aop;
  } cyc_t;

  cyc_t       exp_q[$];
  cyc_t       obs_q[$];
  logic [5:0] cur_op = 6'd0, cur_fn = 6'd0;
  logic [4:0] cur_rt = 5'd0;
  logic       cur_pz = 1'b0;
  int         n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  mips_cpu_state_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .rt_field(rt_field),
    .waitrequest(waitrequest), .pc_is_zero(pc_is_zero),
    .mem_read(mem_read), .mem_write(mem_write), .addr_sel(addr_sel),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .alu_op(alu_op), .active(active), .state(state)
  );

  function automatic logic rnd();
    return 1'($urandom);
  endfunction

  function automatic cyc_t mk(input logic [2:0] st, input logic [6:0] sb,
                              input logic [3:0] aop, input logic wr);
    cyc_t c;
    c = '0;
    c.op = cur_op; c.fn = cur_fn; c.rt = cur_rt; c.pz = cur_pz; c.wr = wr;
    c.st = st;
    {c.mr, c.mw, c.as, c.irw, c.pcw, c.rw, c.act} = sb;
    c.aop = aop;
    return c;
  endfunction

  // First cycle after reset: FETCH, running, nothing strobed.
  function automatic void model_fresh(input logic rs);
    cyc_t c;
    c = mk(3'd0, ACT, 4'd0, rnd());
    c.rs = rs;
    exp_q.push_back(c);
  endfunction

  function automatic void model_halted(input int n, input logic reset_last);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c = mk(3'd5, 7'd0, 4'd0, rnd());
      c.rs = reset_last && (i == n - 1);
      exp_q.push_back(c);
    end
  endfunction

  // Whole instruction as a trace: fst fetch stalls, mst mem stalls;
  // abort_at >= 0 asserts reset in that mem stall and ends the trace.
  function automatic void model_instr(input logic [5:0] op, input logic [5:0] fn,
                                      input logic [4:0] rt, input int fst, input int mst,
                                      input logic pz, input int abort_at);
    int kind;
    logic [3:0] aop;
    logic [6:0] acc;
    cyc_t c;
    cur_op = op; cur_fn = fn; cur_rt = rt; cur_pz = pz;
    kind = K_WB; aop = 4'b0000;
    case (op)
      6'h00: begin aop = 4'b0010; if (fn == 6'h08 || fn == 6'h09) kind = K_PC; end
      6'h01: begin aop = 4'b1011; kind = K_PC; end
      6'h02: kind = K_PC;
      6'h04: begin aop = 4'b0001; kind = K_PC; end
      6'h05: begin aop = 4'b1000; kind = K_PC; end
      6'h06: begin aop = 4'b1010; kind = K_PC; end
      6'h07: begin aop = 4'b1001; kind = K_PC; end
      6'h0a, 6'h0b: aop = 4'b0111;
      6'h0c: aop = 4'b0100;
      6'h0d: aop = 4'b0101;
      6'h0e: aop = 4'b0110;
      6'h23: kind = K_LD;
      6'h2b: kind = K_ST;
      default: kind = K_WB;
    endcase
    for (int i = 0; i < fst; i++) exp_q.push_back(mk(3'd0, MR | ACT, 4'd0, 1'b1));
    exp_q.push_back(mk(3'd0, MR | IRW | ACT, 4'd0, 1'b0));
    exp_q.push_back(mk(3'd1, ACT, 4'd0, rnd()));
    exp_q.push_back(mk(3'd2, (kind == K_PC) ? (PCW | ACT) : ACT, aop, rnd()));
    if (kind == K_LD || kind == K_ST) begin
      acc = AS | ACT | ((kind == K_LD) ? MR : MW);
      for (int i = 0; i < mst; i++) begin
        c = mk(3'd3, acc, 4'd0, 1'b1);
        c.rs = (i == abort_at);
        exp_q.push_back(c);
        if (i == abort_at) return;
      end
      exp_q.push_back(mk(3'd3, (kind == K_ST) ? (acc | PCW) : acc, 4'd0, 1'b0));
    end
    if (kind == K_LD || kind == K_WB) exp_q.push_back(mk(3'd4, RW | PCW | ACT, 4'd0, rnd()));
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    waitrequest = rnd();
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
  endtask

  // Drive each trace record for one cycle and capture the DUT mid-cycle.
  task automatic run_trace();
    cyc_t o;
    obs_q.delete();
    foreach (exp_q[i]) begin
      opcode = exp_q[i].op; funct = exp_q[i].fn; rt_field = exp_q[i].rt;
      reset = exp_q[i].rs; waitrequest = exp_q[i].wr; pc_is_zero = exp_q[i].pz;
      @(negedge clk);
      o = exp_q[i];
      o.st = state; o.mr = mem_read; o.mw = mem_write; o.as = addr_sel;
      o.irw = ir_write; o.pcw = pc_write; o.rw = reg_write; o.act = active;
      o.aop = alu_op;
      obs_q.push_back(o);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 3; i++) model_fresh(1'b1);
    model_fresh(1'b0);
    model_instr(6'h09, 6'h00, 5'd0, 2, 0, 1'b0, -1);
    run_trace();
    foreach (exp_q[i]) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL reset_trace cyc %0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
    n_chk++;
    if ({obs_q[0].st, obs_q[0].act, obs_q[0].mr} !== {3'd0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state got st=%0d act=%b mr=%b exp st=0 act=1 mr=0",
               obs_q[0].st, obs_q[0].act, obs_q[0].mr);
    end
  endtask

  task automatic test_addu();
    logic [2:0] seq [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
    do_reset();
    model_fresh(1'b0);
    model_instr(6'h00, 6'h21, 5'd0, 0, 0, 1'b0, -1);
    model_instr(6'h0d, 6'h00, 5'd0, 0, 0, 1'b0, -1);
    run_trace();
    foreach (exp_q[i]) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL addu_trace cyc %0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (obs_q[i + 1].st !== seq[i]) begin
        n_fail++;
        $display("FAIL addu_seq step %0d got=%0d exp=%0d", i, obs_q[i + 1].st, seq[i]);
      end
    end
    n_chk++;
    if (obs_q[3].aop !== 4'b0010) begin
      n_fail++;
      $display("FAIL addu_aluop got=%b exp=0010", obs_q[3].aop);
    end
    for (int i = 0; i < 6; i++) begin
      n_chk++;
      if (obs_q[i].rw !== (i == 4)) begin
        n_fail++;
        $display("FAIL addu_regwrite cyc %0d got=%b exp=%b", i, obs_q[i].rw, (i == 4));
      end
    end
  endtask

  task automatic test_lw_stall();
    int nmem;
    do_reset();
    model_fresh(1'b0);
    model_instr(6'h23, 6'h00, 5'd0, 1, 3, 1'b0, -1);
    run_trace();
    foreach (exp_q[i]) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL lw_trace cyc %0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
    nmem = 0;
    foreach (obs_q[i]) if (obs_q[i].st == 3'd3 && obs_q[i].mr && obs_q[i].as) nmem++;
    n_chk++;
    if (nmem != 4) begin
      n_fail++;
      $display("FAIL lw_mem_cycles got=%0d exp=4", nmem);
    end
    n_chk++;
    if ({obs_q[9].st, obs_q[9].rw} !== {3'd4, 1'b1}) begin
      n_fail++;
      $display("FAIL lw_writeback got st=%0d rw=%b exp st=4 rw=1", obs_q[9].st, obs_q[9].rw);
    end
  endtask

  task automatic test_bgez();
    do_reset();
    model_fresh(1'b0);
    model_instr(6'h01, 6'h00, 5'd1, 0, 0, 1'b0, -1);
    model_instr(6'h00, 6'h21, 5'd0, 0, 0, 1'b0, -1);
    run_trace();
    foreach (exp_q[i]) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL bgez_trace cyc %0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
    n_chk++;
    if ({obs_q[3].aop, obs_q[3].pcw, obs_q[4].st} !== {4'b1011, 1'b1, 3'd0}) begin
      n_fail++;
      $display("FAIL bgez_exec got aop=%b pcw=%b next=%0d exp aop=1011 pcw=1 next=0",
               obs_q[3].aop, obs_q[3].pcw, obs_q[4].st);
    end
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (obs_q[i].rw !== 1'b0) begin
        n_fail++;
        $display("FAIL bgez_no_regwrite cyc %0d got=%b exp=0", i, obs_q[i].rw);
      end
    end
  endtask

  task automatic test_jr_halt();
    do_reset();
    model_fresh(1'b0);
    model_instr(6'h00, 6'h08, 5'd0, 0, 0, 1'b1, -1);
    model_halted(10, 1'b1);
    model_fresh(1'b0);
    model_instr(6'h00, 6'h21, 5'd0, 0, 0, 1'b0, -1);
    run_trace();
    foreach (exp_q[i]) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL jr_halt_trace cyc %0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
    for (int i = 4; i < 14; i++) begin
      n_chk++;
      if ({obs_q[i].st, obs_q[i].act, obs_q[i].mr, obs_q[i].mw, obs_q[i].irw,
           obs_q[i].pcw, obs_q[i].rw} !== {3'd5, 6'b000000}) begin
        n_fail++;
        $display("FAIL jr_halted cyc %0d got st=%0d act=%b exp st=5 act=0 strobes=0",
                 i, obs_q[i].st, obs_q[i].act);
      end
    end
  endtask

  task automatic test_sw_reset();
    do_reset();
    model_fresh(1'b0);
    model_instr(6'h2b, 6'h00, 5'd0, 0, 3, 1'b0, 1);
    model_fresh(1'b0);
    model_instr(6'h00, 6'h21, 5'd0, 0, 0, 1'b0, -1);
    run_trace();
    foreach (exp_q[i]) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL sw_reset_trace cyc %0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
    for (int i = 0; i < 7; i++) begin
      n_chk++;
      if (obs_q[i].pcw !== 1'b0) begin
        n_fail++;
        $display("FAIL sw_reset_pcwrite cyc %0d got=%b exp=0", i, obs_q[i].pcw);
      end
    end
    n_chk++;
    if ({obs_q[6].st, obs_q[6].mw, obs_q[6].mr} !== {3'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL sw_reset_after got st=%0d mw=%b mr=%b exp st=0 mw=0 mr=0",
               obs_q[6].st, obs_q[6].mw, obs_q[6].mr);
    end
  endtask

  task automatic test_random();
    logic [5:0] ops [20] = '{6'h00, 6'h00, 6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05,
                             6'h06, 6'h07, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e,
                             6'h0f, 6'h23, 6'h2b, 6'h3f};
    logic [5:0] fns [4] = '{6'h21, 6'h08, 6'h09, 6'h2a};
    do_reset();
    model_fresh(1'b0);
    for (int n = 0; n < 150; n++)
      model_instr(ops[$urandom_range(19, 0)], fns[$urandom_range(3, 0)], 5'($urandom),
                  int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), 1'b0, -1);
    run_trace();
    foreach (exp_q[i]) begin
      n_chk++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL random_trace cyc %0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
      n_chk++;
      if ((obs_q[i].mr && obs_q[i].mw) || (obs_q[i].irw && obs_q[i].rw)) begin
        n_fail++;
        $display("FAIL random_exclusion cyc %0d got mr=%b mw=%b irw=%b rw=%b exp no overlap",
                 i, obs_q[i].mr, obs_q[i].mw, obs_q[i].irw, obs_q[i].rw);
      end
    end
  endtask

  initial begin
    reset = 1'b1; waitrequest = 1'b0; pc_is_zero = 1'b0;
    opcode = 6'd0; funct = 6'd0; rt_field = 5'd0;
    @(posedge clk);
    #1;
    test_reset();
    test_addu();
    test_lw_stall();
    test_bgez();
    test_jr_halt();
    test_sw_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
